// File: rtl/inport_controller.sv
// inport_controller: receive-side input port. An external device pushes 32-bit
// words over a valid/ready handshake into a small FIFO, and the CPU pops the
// head word with in_ack during the `in` instruction.
// Optional feature macro: INPORT_OVERRUN_EN (free-running device, sticky
// overrun flag on dropped words). Undefined by default: back-pressure via ext_ready.
module inport_controller #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             ext_valid,
  input  logic [31:0]      ext_data,
  output logic             ext_ready,
  input  logic             in_ack,
  output logic [31:0]      inport_Data,
  output logic             inport_empty,
  output logic             inport_full,
  output logic [PTR_W:0]   inport_count,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Status flags come straight from the registered count.
  assign inport_empty = (count == '0);
  assign inport_full  = (count == FULL_CNT);
  assign inport_count = count;

  // A pop on an empty FIFO is ignored, so an empty push+pop just pushes.
  assign pop = in_ack && !inport_empty;

  // Head word presented to the bus mux; forced to zero while empty.
  assign inport_Data = inport_empty ? 32'h0 : mem[rp];

`ifdef INPORT_OVERRUN_EN
  logic ovr_set;

  // Device never stalls; a full FIFO only accepts when the same edge pops.
  assign ext_ready = 1'b1;
  assign push      = ext_valid && (!inport_full || pop);
  assign ovr_set   = ext_valid && inport_full && !pop;

  // Sticky drop flag; a set on the same edge as a clear request wins.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)            overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end
`else
  logic unused_overrun_clr;

  // Back-pressure from registered state only, so no word is ever lost.
  assign ext_ready          = !inport_full;
  assign push               = ext_valid && ext_ready;
  assign overrun            = 1'b0;
  assign unused_overrun_clr = overrun_clr;
`endif

  // Storage array; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= ext_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inport_controller.sv
// Self-checking bench for inport_controller: directed scenarios plus a
// randomized run, all checked against a queue-based FIFO reference model.
module tb_inport_controller;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef INPORT_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear = 1'b0;
  logic             ext_valid = 1'b0;
  logic [31:0]      ext_data = '0;
  logic             ext_ready;
  logic             in_ack = 1'b0;
  logic [31:0]      inport_Data;
  logic             inport_empty;
  logic             inport_full;
  logic [PTR_W:0]   inport_count;
  logic             overrun;
  logic             overrun_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  bit          m_ovr = 1'b0;

  inport_controller #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .clear(clear), .ext_valid(ext_valid), .ext_data(ext_data),
    .ext_ready(ext_ready), .in_ack(in_ack), .inport_Data(inport_Data),
    .inport_empty(inport_empty), .inport_full(inport_full),
    .inport_count(inport_count), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data();
    return (q.size() != 0) ? q[0] : 32'h0;
  endfunction

  function automatic bit exp_ready();
    return OVR ? 1'b1 : (q.size() < DEPTH);
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic cyc(input bit v, input logic [31:0] d, input bit a, input bit oc = 1'b0);
    bit do_pop, do_push;
    ext_valid = v; ext_data = d; in_ack = a; overrun_clr = oc;
    @(posedge clk);
    do_pop  = a && (q.size() != 0);
    do_push = v && ((q.size() < DEPTH) || (OVR && do_pop));
    if (OVR && v && !do_push) m_ovr = 1'b1;
    else if (OVR && oc)       m_ovr = 1'b0;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
    ext_valid = 1'b0; in_ack = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; #2; clear = 1'b0;
    q.delete(); m_ovr = 1'b0;
    cyc(1, 32'hDEAD_0001, 0);
    cyc(1, 32'hDEAD_0002, 0);
    // Assert reset mid-cycle with a word on offer; it must be lost.
    #2; clear = 1'b1; ext_valid = 1'b1; ext_data = 32'hBAD0_BAD0; #1;
    q.delete(); m_ovr = 1'b0;
    checks++; if (int'(inport_count) !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", inport_count); end
    checks++; if (inport_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", inport_empty); end
    checks++; if (inport_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", inport_full); end
    checks++; if (inport_Data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", inport_Data); end
    checks++; if (ext_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ext_ready); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    clear = 1'b0; ext_valid = 1'b0;
    checks++; if (inport_empty !== 1'b1) begin failures++; $display("FAIL reset_word_lost empty=%b exp=1", inport_empty); end
  endtask

  task automatic test_single();
    cyc(1, 32'h0000_00A5, 0);
    checks++; if (inport_Data !== 32'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", inport_Data); end
    checks++; if (int'(inport_count) !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", inport_count); end
    checks++; if (inport_empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", inport_empty); end
    cyc(0, 0, 1);
    checks++; if (inport_empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", inport_empty); end
    checks++; if (inport_Data !== 32'h0) begin failures++; $display("FAIL single_pop_data got=%h exp=0", inport_Data); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) cyc(1, 32'(i * 32'h11), 0);
    checks++; if (inport_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", inport_full); end
    checks++; if (ext_ready !== exp_ready()) begin failures++; $display("FAIL fill_ready got=%b exp=%b", ext_ready, exp_ready()); end
    checks++; if (int'(inport_count) !== DEPTH) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", inport_count, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (inport_Data !== 32'(i * 32'h11)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, inport_Data, 32'(i * 32'h11)); end
      cyc(0, 0, 1);
    end
    checks++; if (inport_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", inport_empty); end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    cyc(1, 32'hA000_0001, 0);
    cyc(1, 32'hA000_0002, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, $urandom, 1);
      checks++; if (int'(inport_count) !== 2) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, inport_count); end
      checks++; if (inport_Data !== exp_data()) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, inport_Data, exp_data()); end
    end
    while (q.size() != 0) begin
      checks++; if (inport_Data !== exp_data()) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", inport_Data, exp_data()); end
      cyc(0, 0, 1);
    end
    w = $urandom;
    cyc(1, w, 1);
    checks++; if (int'(inport_count) !== 1) begin failures++; $display("FAIL empty_pushpop_count got=%0d exp=1", inport_count); end
    checks++; if (inport_Data !== w) begin failures++; $display("FAIL empty_pushpop_data got=%h exp=%h", inport_Data, w); end
    cyc(0, 0, 1);
  endtask

  task automatic test_empty_pop();
    logic [31:0] w;
    cyc(0, 0, 1);
    checks++; if (int'(inport_count) !== 0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", inport_count); end
    checks++; if (inport_Data !== 32'h0) begin failures++; $display("FAIL empty_pop_data got=%h exp=0", inport_Data); end
    w = 32'h1234_5678;
    cyc(1, w, 0);
    checks++; if (inport_Data !== w) begin failures++; $display("FAIL empty_pop_next got=%h exp=%h", inport_Data, w); end
    cyc(0, 0, 1);
  endtask

`ifdef INPORT_OVERRUN_EN
  task automatic test_overrun();
    for (int i = 1; i <= DEPTH; i++) cyc(1, 32'(i * 32'h11), 0);
    cyc(1, 32'h55, 0);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (int'(inport_count) !== DEPTH) begin failures++; $display("FAIL ovr_count got=%0d exp=%0d", inport_count, DEPTH); end
    cyc(1, 32'h66, 0, 1);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (inport_Data !== 32'(i * 32'h11)) begin failures++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, inport_Data, 32'(i * 32'h11)); end
      cyc(0, 0, 1);
    end
    cyc(0, 0, 0, 1);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      checks++; if (int'(inport_count) !== q.size()) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, inport_count, q.size()); end
      checks++; if (inport_Data !== exp_data()) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, inport_Data, exp_data()); end
      checks++; if (inport_empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty[%0d] got=%b", i, inport_empty); end
      checks++; if (inport_full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full[%0d] got=%b", i, inport_full); end
      checks++; if (ext_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, ext_ready, exp_ready()); end
      checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rnd_overrun[%0d] got=%b exp=%b", i, overrun, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_wrap();
    test_empty_pop();
`ifdef INPORT_OVERRUN_EN
    test_overrun();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
